// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: segment bit positions, the dark pattern and hex glyphs.
// Pure constants; no latency, no backpressure.
package seven_segment_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] M_A = 7'(1 << SEG_A);
    localparam logic [6:0] M_B = 7'(1 << SEG_B);
    localparam logic [6:0] M_C = 7'(1 << SEG_C);
    localparam logic [6:0] M_D = 7'(1 << SEG_D);
    localparam logic [6:0] M_E = 7'(1 << SEG_E);
    localparam logic [6:0] M_F = 7'(1 << SEG_F);
    localparam logic [6:0] M_G = 7'(1 << SEG_G);

    // Active-high "all segments dark"; drivers invert it for common-anode parts.
    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    // Entry n is the active-high glyph for hex digit n, bit order {g,f,e,d,c,b,a}.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        M_A | M_E | M_F | M_G,                     // F
        M_A | M_D | M_E | M_F | M_G,               // E
        M_B | M_C | M_D | M_E | M_G,               // d
        M_A | M_D | M_E | M_F,                     // C
        M_C | M_D | M_E | M_F | M_G,               // b
        M_A | M_B | M_C | M_E | M_F | M_G,         // A
        M_A | M_B | M_C | M_D | M_F | M_G,         // 9
        M_A | M_B | M_C | M_D | M_E | M_F | M_G,   // 8
        M_A | M_B | M_C,                           // 7
        M_A | M_C | M_D | M_E | M_F | M_G,         // 6
        M_A | M_C | M_D | M_F | M_G,               // 5
        M_B | M_C | M_F | M_G,                     // 4
        M_A | M_B | M_C | M_D | M_G,               // 3
        M_A | M_B | M_D | M_E | M_G,               // 2
        M_B | M_C,                                 // 1
        M_A | M_B | M_C | M_D | M_E | M_F          // 0
    };

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex nibble to active-high seven-segment glyph.
// Latency: combinational. Backpressure: none.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed hex display driver with frame-coherent updates, leading-zero blanking and PWM dimming.
// Latency: pins lag the slot/digit counters by one clock. Backpressure: none; load is accepted every cycle.
module seven_segment_scan_driver
    import seven_segment_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        load,
    input  logic [4*N_DIGITS-1:0]       value,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic                        blank_lz,
    input  logic [3:0]                  brightness,
    output logic [6:0]                  segments,
    output logic                        dp,
    output logic [N_DIGITS-1:0]         anode,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DIG_W = $clog2(N_DIGITS);
    localparam int STEP  = SCAN_DIV / 16;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [DIG_W-1:0]      r_dig;
    logic [3:0]            r_bright;
    logic [4*N_DIGITS-1:0] r_pend_val;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic [4*N_DIGITS-1:0] r_shad_val;
    logic [N_DIGITS-1:0]   r_shad_dp;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_anode;
    logic [DIG_W-1:0]      r_dig_out;
    logic                  r_frame_start;

    logic                  w_slot_start;
    logic                  w_slot_last;
    logic                  w_frame_wrap;
    logic [3:0]            w_bright;
    logic [CNT_W:0]        w_thresh;
    logic                  w_duty_on;
    logic [3:0]            w_nibble;
    logic                  w_upper_zero;
    logic                  w_blank;
    logic                  w_lit;
    logic [6:0]            w_seg_hi;
    logic [N_DIGITS-1:0]   w_onehot;

    assign w_slot_start = (r_cnt == '0);
    assign w_slot_last  = (r_cnt == CNT_LAST);
    assign w_frame_wrap = enable && w_slot_last && (r_dig == DIG_LAST);

    // Cycle 0 of a slot uses the live code so the whole slot sees one sampled value.
    assign w_bright  = w_slot_start ? brightness : r_bright;
    assign w_thresh  = (CNT_W+1)'((int'(w_bright) + 1) * STEP);
    assign w_duty_on = ({1'b0, r_cnt} < w_thresh);

    assign w_nibble = r_shad_val[{r_dig, 2'b00} +: 4];

    always_comb begin
        w_upper_zero = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(r_dig) && r_shad_val[4*i +: 4] != 4'h0) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_blank  = blank_lz && (r_dig != '0) && w_upper_zero;
    assign w_lit    = enable && !w_blank && w_duty_on;
    assign w_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_dig;

    seven_segment_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_dig         <= '0;
            r_bright      <= '0;
            r_pend_val    <= '0;
            r_pend_dp     <= '0;
            r_shad_val    <= '0;
            r_shad_dp     <= '0;
            r_seg         <= SEG_OFF ^ {7{POL}};
            r_dp          <= POL;
            r_anode       <= {N_DIGITS{POL}};
            r_dig_out     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
            end
            // A coincident load lands in pending while the older pending moves to shadow.
            if (w_frame_wrap) begin
                r_shad_val <= r_pend_val;
                r_shad_dp  <= r_pend_dp;
            end

            r_frame_start <= enable && w_slot_start && (r_dig == '0);
            r_dig_out     <= enable ? r_dig : '0;
            r_seg         <= (w_lit ? w_seg_hi : SEG_OFF) ^ {7{POL}};
            r_dp          <= (w_lit && r_shad_dp[r_dig]) ^ POL;
            r_anode       <= (w_lit ? w_onehot : '0) ^ {N_DIGITS{POL}};

            if (!enable) begin
                r_cnt <= '0;
                r_dig <= '0;
            end else begin
                if (w_slot_start) begin
                    r_bright <= brightness;
                end
                if (w_slot_last) begin
                    r_cnt <= '0;
                    r_dig <= (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign segments    = r_seg;
    assign dp          = r_dp;
    assign anode       = r_anode;
    assign digit_idx   = r_dig_out;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver at N_DIGITS=4, SCAN_DIV=16, ACTIVE_LOW=1.
module tb_seven_segment_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 16;
    localparam logic [14:0] OFF_VEC = {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_start;
    logic [14:0] obs;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpo;
        int         on_cyc;
    } slot_t;

    slot_t exp_q[$];

    always #5 clk = ~clk;

    assign obs = {anode, segments, dp, frame_start, digit_idx};

    seven_segment_scan_driver #(
        .N_DIGITS   (N),
        .SCAN_DIV   (DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .segments    (segments),
        .dp          (dp),
        .anode       (anode),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    // Expected pin values for one frame, digit 0 first, active-low.
    task automatic push_frame(input logic [15:0] val, input logic [3:0] dps,
                              input logic blz, input int br);
        for (int d = 0; d < N; d++) begin
            slot_t e;
            logic  blank;
            blank    = blz && (d > 0) && ((val >> (4*d)) == 16'h0);
            e.an     = ~(4'b0001 << d);
            e.seg    = ~ref_glyph(val[4*d +: 4]);
            e.dpo    = ~dps[d];
            e.on_cyc = blank ? 0 : (br + 1) * DIV / 16;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_load(input logic [15:0] val, input logic [3:0] dps);
        value = val;
        dp_in = dps;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Pops one expected slot per digit and compares every cycle of the frame.
    task automatic run_frames(input string name, input int nframes, input int maxw);
        for (int f = 0; f < nframes; f++) begin
            int w;
            int lim;
            w   = 0;
            lim = (f == 0) ? maxw : 0;
            while (frame_start !== 1'b1 && w < lim) begin
                @(negedge clk);
                w++;
            end
            n_vec++;
            if (frame_start !== 1'b1) begin
                n_fail++;
                $display("FAIL %s frame %0d start: frame_start=%b after %0d cycles, required 1 within %0d",
                         name, f, frame_start, w, lim);
                for (int d = 0; d < N; d++) if (exp_q.size() > 0) void'(exp_q.pop_front());
                continue;
            end
            for (int d = 0; d < N; d++) begin
                slot_t e;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s scoreboard: queue empty at frame %0d digit %0d, required an entry", name, f, d);
                    return;
                end
                e = exp_q.pop_front();
                for (int c = 0; c < DIV; c++) begin
                    logic [14:0] expv;
                    logic        fs;
                    fs   = (d == 0) && (c == 0);
                    expv = (c < e.on_cyc) ? {e.an, e.seg, e.dpo, fs, 2'(d)}
                                          : {4'hF, 7'h7F, 1'b1, fs, 2'(d)};
                    n_vec++;
                    if (obs !== expv) begin
                        n_fail++;
                        $display("FAIL %s f%0d d%0d c%0d: observed an=%b seg=%b dp=%b fs=%b idx=%0d, required an=%b seg=%b dp=%b fs=%b idx=%0d",
                                 name, f, d, c, obs[14:11], obs[10:4], obs[3], obs[2], obs[1:0],
                                 expv[14:11], expv[10:4], expv[3], expv[2], expv[1:0]);
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== OFF_VEC) begin
            n_fail++;
            $display("FAIL reset_async: observed %h, required %h", obs, OFF_VEC);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (obs !== OFF_VEC) begin
            n_fail++;
            $display("FAIL reset_held: observed %h, required %h", obs, OFF_VEC);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (obs !== OFF_VEC) begin
            n_fail++;
            $display("FAIL reset_released_disabled: observed %h, required %h", obs, OFF_VEC);
        end
    endtask

    task automatic test_display;
        pulse_load(16'h9999, 4'b1111);
        pulse_load(16'h1234, 4'b0101);
        enable = 1'b1;
        push_frame(16'h0000, 4'b0000, 1'b0, 15);
        push_frame(16'h1234, 4'b0101, 1'b0, 15);
        run_frames("display", 2, 1);
    endtask

    task automatic test_blanking;
        blank_lz = 1'b1;
        pulse_load(16'h0050, 4'b1001);
        push_frame(16'h0050, 4'b1001, 1'b1, 15);
        run_frames("blank_0050", 1, 100);
        pulse_load(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0000, 1'b1, 15);
        run_frames("blank_0000", 1, 100);
        blank_lz = 1'b0;
    endtask

    task automatic test_brightness;
        brightness = 4'd3;
        pulse_load(16'h1234, 4'b0101);
        push_frame(16'h1234, 4'b0101, 1'b0, 3);
        run_frames("bright3", 1, 100);
        brightness = 4'd0;
        repeat (DIV*N) @(negedge clk);
        push_frame(16'h1234, 4'b0101, 1'b0, 0);
        run_frames("bright0", 1, 0);
        brightness = 4'd15;
        repeat (DIV*N) @(negedge clk);
    endtask

    task automatic test_coherent;
        push_frame(16'h1234, 4'b0101, 1'b0, 15);
        push_frame(16'hABCD, 4'b0000, 1'b0, 15);
        fork
            run_frames("coherent", 2, 0);
            begin
                repeat (20) @(negedge clk);
                pulse_load(16'hABCD, 4'b0000);
            end
        join
    endtask

    task automatic test_boundary_load;
        push_frame(16'hABCD, 4'b0000, 1'b0, 15);
        push_frame(16'h5678, 4'b0011, 1'b0, 15);
        push_frame(16'h9EF0, 4'b1100, 1'b0, 15);
        fork
            run_frames("boundary_load", 3, 0);
            begin
                repeat (10) @(negedge clk);
                pulse_load(16'h5678, 4'b0011);
                repeat (51) @(negedge clk);
                pulse_load(16'h9EF0, 4'b1100);
            end
        join
    endtask

    task automatic test_reset_mid;
        pulse_load(16'h4321, 4'b1111);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== OFF_VEC) begin
            n_fail++;
            $display("FAIL reset_mid_async: observed %h, required %h", obs, OFF_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0000, 4'b0000, 1'b0, 15);
        push_frame(16'h0000, 4'b0000, 1'b0, 15);
        run_frames("reset_restart", 2, 1);
    endtask

    task automatic test_enable_toggle;
        pulse_load(16'h2468, 4'b0010);
        repeat (DIV*N - 1) @(negedge clk);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (obs !== OFF_VEC) begin
                n_fail++;
                $display("FAIL enable_off cycle %0d: observed %h, required %h", i, obs, OFF_VEC);
            end
            if (i == 9) pulse_load(16'h1357, 4'b0100);
            else @(negedge clk);
        end
        enable = 1'b1;
        push_frame(16'h2468, 4'b0010, 1'b0, 15);
        push_frame(16'h1357, 4'b0100, 1'b0, 15);
        run_frames("enable_restart", 2, 1);
    endtask

    initial begin
        test_reset;
        test_display;
        test_blanking;
        test_brightness;
        test_coherent;
        test_boundary_load;
        test_reset_mid;
        test_enable_toggle;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
